window_scan_ctrl: RTL and testbench
===================================

WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 64, meaning image width in pixels (must be at least 3).
REQ-002 The block SHALL have parameter IMG_H, default 64, meaning image height in pixels (must be at least 3).
REQ-003 The block SHALL have parameter ADDR_W, default 12, meaning pixel-memory address width (must be at least clog2(IMG_W*IMG_H)).
REQ-004 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: begins a full-frame scan; sampled in IDLE only.
REQ-007 Port mem_rd, output, 1 bit: pixel-memory read strobe.
REQ-008 Port mem_addr, output, ADDR_W bits: pixel address, row-major, equal to y*IMG_W + x.
REQ-009 Port mem_data, input, 24 bits: RGB pixel {R[23:16],G[15:8],B[7:0]}, valid the cycle after mem_rd.
REQ-010 Port win, output, 216 bits: packed 3x3 window.
REQ-011 Port load, output, 1 bit: one-cycle capture strobe to the register bank.
REQ-012 Port win_valid, output, 1 bit: window loaded and awaiting consumption.
REQ-013 Port win_ready, input, 1 bit: downstream accepts the current window.
REQ-014 Port cx, output, 16 bits: current window centre column.
REQ-015 Port cy, output, 16 bits: current window centre row.
REQ-016 Port busy, output, 1 bit: high in every state except IDLE.
REQ-017 Port done, output, 1 bit: one-cycle pulse after the last window is accepted.

Function
REQ-018 States SHALL be IDLE, FETCH, CAPT, LOAD, VALID and DONE; the block SHALL leave IDLE only on start=1 and go to FETCH.
REQ-019 Window centres SHALL scan x=1..IMG_W-2 (inner loop) and y=1..IMG_H-2 (outer loop), giving (IMG_W-2)*(IMG_H-2) windows per frame; the first centre is (1,1).
REQ-020 FETCH SHALL last exactly 9 cycles, with mem_rd=1 each cycle and index k=0..8 addressing (cy-1+k/3, cx-1+k%3).
REQ-021 The mem_data returned for index k SHALL be stored at win[215-24k : 192-24k], so a (top-left) occupies the MSBs and i (bottom-right) bits 23:0.
REQ-022 CAPT SHALL last 1 cycle, capture the index-8 pixel, and hold mem_rd=0.
REQ-023 LOAD SHALL last 1 cycle with load=1; win SHALL be complete and stable from LOAD until the next FETCH.
REQ-024 VALID SHALL hold win_valid=1 until win_ready=1 is sampled; win, cx and cy SHALL be stable throughout VALID.
REQ-025 On acceptance of a window that is not the last, the block SHALL advance the centre (x+1; on wrap from IMG_W-2, x=1 and y+1) and enter FETCH.
REQ-026 On acceptance of the last window (IMG_W-2, IMG_H-2), the block SHALL enter DONE for 1 cycle with done=1, then return to IDLE.
REQ-027 Minimum per-window latency SHALL be 12 cycles (FETCH 9, CAPT 1, LOAD 1, VALID 1).
REQ-028 A start asserted outside IDLE SHALL be ignored; a start asserted during the DONE cycle SHALL be ignored.
REQ-029 Outputs load, mem_rd, win_valid and done SHALL never be asserted at the same time.
REQ-030 win_ready asserted outside VALID SHALL have no effect.

Reset
REQ-031 On rst=1 at any time, including mid-FETCH or mid-VALID, the block SHALL immediately enter IDLE and drive mem_rd=0, mem_addr=0, win=0, load=0, win_valid=0, cx=1, cy=1, busy=0 and done=0.
REQ-032 After reset release, the block SHALL remain in IDLE until start=1 is sampled; a partial frame SHALL NOT resume.

Structure
REQ-033 Shared package haze_pkg SHALL hold PIX_W=24, KSIZE=3, WIN_W=216 and the scan-state enumeration.
REQ-034 A sub-module window_addr_gen SHALL compute mem_addr from (cx, cy, k); the FSM, centre counters and window packing SHALL remain in window_scan_ctrl.

Verification
REQ-035 Scenario: IMG_W=IMG_H=4, mem_data = {addr[7:0] x3}, win_ready tied to 1, start pulsed -> exactly 4 windows; first win = pixel addresses 0,1,2,4,5,6,8,9,10 with a at the MSBs; done 48 cycles after FETCH entry.
REQ-036 Scenario: hold win_ready=0 for 20 cycles in the first VALID -> win_valid stays high, win/cx/cy stay constant, and no mem_rd is issued.
REQ-037 Scenario: pulse start during FETCH and again during DONE -> no extra frame and the window count is unchanged.
REQ-038 Scenario: assert rst in FETCH cycle 5 -> all outputs take their reset values in the same cycle; a subsequent start rescans from (1,1).
REQ-039 Scenario: IMG_W=5, IMG_H=3 -> centres (1,1),(2,1),(3,1) in order, then a done pulse; the address sequence matches the row-major formula.
REQ-040 Scenario: an assertion checker runs across all of the above -> load is a single-cycle pulse each time and REQ-029 exclusivity holds in every cycle.

Source files
------------

// File: rtl/haze_pkg.sv
// Shared widths and scan-state encoding for the 3x3 RGB window scanner.
package haze_pkg;

  localparam int PIX_W = 24;
  localparam int KSIZE = 3;
  localparam int NTAPS = KSIZE * KSIZE;
  localparam int WIN_W = NTAPS * PIX_W;  // 216

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_LOAD,
    S_VALID,
    S_DONE
  } scan_state_e;

endpackage

// File: rtl/window_addr_gen.sv
// Row-major pixel address of tap k (0..8) of the 3x3 window centred on (cx, cy).
module window_addr_gen #(
  parameter int IMG_W  = 64,
  parameter int ADDR_W = 12
) (
  input  logic [15:0]       cx,
  input  logic [15:0]       cy,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr
);

  logic [1:0]  row_off;
  logic [1:0]  col_off;
  logic [31:0] row;
  logic [31:0] col;

  // Table lookup in place of k/3 and k%3 keeps the divider out of the address path.
  always_comb begin
    unique case (k)
      4'd0, 4'd1, 4'd2: row_off = 2'd0;
      4'd3, 4'd4, 4'd5: row_off = 2'd1;
      default:          row_off = 2'd2;
    endcase
    unique case (k)
      4'd0, 4'd3, 4'd6: col_off = 2'd0;
      4'd1, 4'd4, 4'd7: col_off = 2'd1;
      default:          col_off = 2'd2;
    endcase
    row  = 32'(cy) - 32'd1 + 32'(row_off);
    col  = 32'(cx) - 32'd1 + 32'(col_off);
    addr = ADDR_W'(row * 32'(IMG_W) + col);
  end

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame scanner: fetches every interior 3x3 RGB window from pixel memory and
// hands it downstream with a valid/ready handshake.
module window_scan_ctrl
  import haze_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [WIN_W-1:0]  win,
  output logic              load,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [15:0]       cx,
  output logic [15:0]       cy,
  output logic              busy,
  output logic              done
);

  localparam logic [15:0] CX_LAST = 16'(IMG_W - 2);
  localparam logic [15:0] CY_LAST = 16'(IMG_H - 2);

  scan_state_e       state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [15:0]       cx_q, cx_d;
  logic [15:0]       cy_q, cy_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [ADDR_W-1:0] tap_addr;
  logic [3:0]        slot;
  logic              capture;

  window_addr_gen #(
    .IMG_W (IMG_W),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .cx  (cx_q),
    .cy  (cy_q),
    .k   (k_q),
    .addr(tap_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 4'd0;
      cx_q    <= 16'd1;
      cy_q    <= 16'd1;
      // NOTE: the window bank is reset even though it is datapath, because win
      // is a visible output whose reset value is 0.
      win_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      state_q <= state_d;
      k_q     <= k_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      win_q   <= win_d;
    end
  end

  // Read data lags mem_rd by a cycle: FETCH step k stores tap k-1, CAPT stores tap 8.
  assign capture = ((state_q == S_FETCH) && (k_q != 4'd0)) || (state_q == S_CAPT);
  assign slot    = (state_q == S_CAPT) ? 4'd8 : (k_q - 4'd1);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    k_d     = k_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    win_d   = win_q;

    if (capture) begin
      win_d[(WIN_W - 1) - PIX_W * int'(slot) -: PIX_W] = mem_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          k_d     = 4'd0;
          cx_d    = 16'd1;
          cy_d    = 16'd1;
        end
      end
      S_FETCH: begin
        if (k_q == 4'd8) begin
          state_d = S_CAPT;
          k_d     = 4'd0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_CAPT:  state_d = S_LOAD;
      S_LOAD:  state_d = S_VALID;
      S_VALID: begin
        if (win_ready) begin
          if (cx_q != CX_LAST) begin
            cx_d    = cx_q + 16'd1;
            state_d = S_FETCH;
          end else if (cy_q != CY_LAST) begin
            cx_d    = 16'd1;
            cy_d    = cy_q + 16'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_rd    = (state_q == S_FETCH);
  assign mem_addr  = mem_rd ? tap_addr : '0;
  assign load      = (state_q == S_LOAD);
  assign win_valid = (state_q == S_VALID);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign win       = win_q;
  assign cx        = cx_q;
  assign cy        = cy_q;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench: a 4x4 and a 5x3 instance share clock/reset; a mux picks which
// one the scenario drives and observes.
module tb_window_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  logic         sel;
  logic         m_start, m_ready;

  logic         start4, rd4, load4, wv4, ready4, busy4, done4;
  logic [11:0]  addr4;
  logic [23:0]  data4;
  logic [215:0] win4;
  logic [15:0]  cx4, cy4;

  logic         start53, rd53, load53, wv53, ready53, busy53, done53;
  logic [11:0]  addr53;
  logic [23:0]  data53;
  logic [215:0] win53;
  logic [15:0]  cx53, cy53;

  assign start4  = ~sel & m_start;
  assign ready4  = ~sel & m_ready;
  assign start53 = sel & m_start;
  assign ready53 = sel & m_ready;

  window_scan_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(12)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .mem_rd(rd4), .mem_addr(addr4),
    .mem_data(data4), .win(win4), .load(load4), .win_valid(wv4),
    .win_ready(ready4), .cx(cx4), .cy(cy4), .busy(busy4), .done(done4)
  );

  window_scan_ctrl #(.IMG_W(5), .IMG_H(3), .ADDR_W(12)) u_d53 (
    .clk(clk), .rst(rst), .start(start53), .mem_rd(rd53), .mem_addr(addr53),
    .mem_data(data53), .win(win53), .load(load53), .win_valid(wv53),
    .win_ready(ready53), .cx(cx53), .cy(cy53), .busy(busy53), .done(done53)
  );

  // Pixel memory: one-cycle read latency, pixel value = address byte in R, G and B.
  logic [11:0] raddr4_q  = '0;
  logic [11:0] raddr53_q = '0;
  always @(posedge clk) begin
    raddr4_q  <= addr4;
    raddr53_q <= addr53;
  end
  assign data4  = {3{raddr4_q[7:0]}};
  assign data53 = {3{raddr53_q[7:0]}};

  logic         m_rd, m_load, m_wv, m_busy, m_done;
  logic [11:0]  m_addr;
  logic [215:0] m_win;
  logic [15:0]  m_cx, m_cy;

  always_comb begin
    if (sel) begin
      m_rd = rd53; m_load = load53; m_wv = wv53; m_busy = busy53; m_done = done53;
      m_addr = addr53; m_win = win53; m_cx = cx53; m_cy = cy53;
    end else begin
      m_rd = rd4; m_load = load4; m_wv = wv4; m_busy = busy4; m_done = done4;
      m_addr = addr4; m_win = win4; m_cx = cx4; m_cy = cy4;
    end
  end

  task automatic check(input string tag, input logic [215:0] got, input logic [215:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe exclusivity and single-cycle load on both instances, every cycle.
  logic prev_load4  = 1'b0;
  logic prev_load53 = 1'b0;
  always @(negedge clk) begin
    check("excl4",  ($countones({load4, rd4, wv4, done4}) <= 1), 1'b1);
    check("excl53", ($countones({load53, rd53, wv53, done53}) <= 1), 1'b1);
    check("load_pulse4",  load4 & prev_load4, 1'b0);
    check("load_pulse53", load53 & prev_load53, 1'b0);
    prev_load4  <= load4;
    prev_load53 <= load53;
  end

  task automatic check_reset(input string tag);
    check({tag, "_rd"},    m_rd,    1'b0);
    check({tag, "_addr"},  m_addr,  12'd0);
    check({tag, "_win"},   m_win,   216'd0);
    check({tag, "_load"},  m_load,  1'b0);
    check({tag, "_valid"}, m_wv,    1'b0);
    check({tag, "_cx"},    m_cx,    16'd1);
    check({tag, "_cy"},    m_cy,    16'd1);
    check({tag, "_busy"},  m_busy,  1'b0);
    check({tag, "_done"},  m_done,  1'b0);
  endtask

  // Called at a negedge with m_start already raised. Cycle c=0 is the first FETCH cycle.
  task automatic run_frame(input int img_w, input int stall, input bit poke_start,
                           output int n_win, output int done_cyc, output logic [215:0] first_win);
    int k, w, vcnt, nd, ecx, ecy, fetch_start, last_accept;
    logic [11:0]  ea;
    logic [215:0] ewin, snap;
    bit fin;
    n_win = 0; done_cyc = -1; first_win = '0;
    k = 0; w = 0; vcnt = 0; nd = 0; fin = 0;
    fetch_start = 0; last_accept = -1; ewin = '0; snap = '0;
    m_ready = (stall == 0);
    @(negedge clk);
    m_start = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      ecx = 1 + w % (img_w - 2);
      ecy = 1 + w / (img_w - 2);
      if (poke_start) m_start = (c == 3);
      if (m_rd) begin
        if (k == 0) begin
          check("fetch_at", c, last_accept + 1);
          fetch_start = c;
          ewin = '0;
        end
        ea = 12'((ecy - 1 + k / 3) * img_w + (ecx - 1 + k % 3));
        check("mem_addr", m_addr, ea);
        if (k < 9) ewin[215 - 24 * k -: 24] = {3{ea[7:0]}};
        k++;
      end
      if (m_load) check("load_at", c, fetch_start + 10);
      if (m_wv) begin
        if (vcnt == 0) begin
          check("rd_count", k, 9);
          check("valid_at", c, fetch_start + 11);
          check("cx", m_cx, ecx);
          check("cy", m_cy, ecy);
          check("win", m_win, ewin);
          snap = m_win;
          if (w == 0) first_win = m_win;
        end else begin
          check("hold_win", m_win, snap);
          check("hold_cx", m_cx, ecx);
          check("hold_cy", m_cy, ecy);
          check("hold_no_rd", m_rd, 1'b0);
        end
        vcnt++;
        if (stall != 0 && w == 0 && vcnt == stall) m_ready = 1'b1;
        if (m_ready) begin
          n_win++; w++; k = 0; vcnt = 0; last_accept = c;
        end
      end
      if (m_done) begin
        nd++;
        done_cyc = c;
        check("done_at", c, last_accept + 1);
        if (poke_start) m_start = 1'b1;
      end else if (done_cyc >= 0) begin
        fin = 1'b1;
        m_start = 1'b0;
        check("idle_after_done", m_busy, 1'b0);
      end
      if (!fin) @(negedge clk);
    end
    check("frame_end", fin, 1'b1);
    check("done_pulses", nd, 1);
  endtask

  localparam logic [215:0] FIRST_WIN4 =
    216'h000000_010101_020202_040404_050505_060606_080808_090909_0a0a0a;

  int nw, dc;
  logic [215:0] fw;

  initial begin
    n_checks = 0; n_errors = 0;
    sel = 1'b0; m_start = 1'b0; m_ready = 1'b0; rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start", m_busy, 1'b0);

    // Full 4x4 frame with ready tied high.
    m_start = 1'b1;
    run_frame(4, 0, 1'b0, nw, dc, fw);
    check("f1_windows", nw, 4);
    check("f1_done_cyc", dc, 48);
    check("f1_first_win", fw, FIRST_WIN4);

    // Downstream stalls 20 cycles on the first window.
    @(negedge clk);
    m_start = 1'b1;
    run_frame(4, 20, 1'b0, nw, dc, fw);
    check("f2_windows", nw, 4);
    check("f2_done_cyc", dc, 67);

    // Start pulsed mid-FETCH and during DONE must not launch anything.
    @(negedge clk);
    m_start = 1'b1;
    run_frame(4, 0, 1'b1, nw, dc, fw);
    check("f3_windows", nw, 4);
    check("f3_done_cyc", dc, 48);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("f3_no_extra", {m_busy, m_rd}, 2'b00);
    end

    // Reset in FETCH cycle 5, then a fresh scan from (1,1).
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    repeat (5) @(negedge clk);
    check("fetch5_rd", m_rd, 1'b1);
    check("fetch5_addr", m_addr, 12'd6);
    #1 rst = 1'b1;
    #1 check_reset("mid_fetch");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_resume", {m_busy, m_rd}, 2'b00);
    end
    m_start = 1'b1;
    run_frame(4, 0, 1'b0, nw, dc, fw);
    check("f4_windows", nw, 4);
    check("f4_done_cyc", dc, 48);
    check("f4_first_win", fw, FIRST_WIN4);

    // 5x3 image: centres (1,1),(2,1),(3,1) then done.
    @(negedge clk);
    sel = 1'b1;
    m_start = 1'b1;
    run_frame(5, 0, 1'b0, nw, dc, fw);
    check("f5_windows", nw, 3);
    check("f5_done_cyc", dc, 36);
    check("f5_first_win", fw,
          216'h000000_010101_020202_050505_060606_070707_0a0a0a_0b0b0b_0c0c0c);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
